// File: rtl/mpe_scheduler.sv
// mpe_scheduler: sequences one matrix-vector command into per-output uops, NRAM/WRAM read streams and result writes.
// Define MPE_SCHED_RELU_EN to clamp negative PE results to zero before they are written.
module mpe_scheduler #(
  parameter int AW = 16,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [CW-1:0] cmd_iter,
  input  logic [CW-1:0] cmd_nout,
  input  logic [AW-1:0] cmd_nram_addr,
  input  logic [AW-1:0] cmd_wram_addr,
  input  logic [AW-1:0] cmd_out_addr,
  output logic [CW-1:0] uop,
  output logic          uop_valid,
  input  logic          uop_ready,
  output logic [AW-1:0] nram_rd_addr,
  output logic          nram_rd_valid,
  input  logic          nram_rd_ready,
  output logic [AW-1:0] wram_rd_addr,
  output logic          wram_rd_valid,
  input  logic          wram_rd_ready,
  input  logic [31:0]   pe_result,
  input  logic          pe_vld,
  output logic          out_wr_en,
  output logic [AW-1:0] out_wr_addr,
  output logic [31:0]   out_wr_data,
  output logic          busy,
  output logic          done
);
  typedef enum logic [1:0] {IDLE, ISSUE, STREAM, DRAIN} state_t;
  state_t state, state_n;
  logic [CW-1:0] iter, target, out_idx, res_cnt, nram_cnt, wram_cnt;
  logic [AW-1:0] nram_base, wram_ptr, out_base;
  logic accept, zero_cmd, capture, both_done, last, nram_fire, wram_fire;
  logic [31:0] wr_data;

  assign zero_cmd = cmd_iter == '0 || cmd_nout == '0;
  assign both_done = nram_cnt == iter && wram_cnt == iter;
  assign last = out_idx == target - CW'(1);
  // done is decoded so the next command can be taken in the same cycle
  assign done = state == DRAIN && res_cnt == target && !out_wr_en;
  assign cmd_ready = state == IDLE || done;
  assign accept = cmd_valid && cmd_ready;
  assign busy = state != IDLE;
  assign uop = iter;
  assign uop_valid = state == ISSUE;
  assign nram_rd_valid = state == STREAM && nram_cnt < iter;
  assign nram_rd_addr = nram_base + AW'(nram_cnt);
  assign wram_rd_valid = state == STREAM && wram_cnt < iter;
  assign wram_rd_addr = wram_ptr;
  assign nram_fire = nram_rd_valid && nram_rd_ready;
  assign wram_fire = wram_rd_valid && wram_rd_ready;
  assign capture = state != IDLE && pe_vld && res_cnt < target;

`ifdef MPE_SCHED_RELU_EN
  assign wr_data = pe_result[31] ? 32'd0 : pe_result;
`else
  assign wr_data = pe_result;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;

  always_comb begin
    state_n = state;
    case (state)
      ISSUE:   if (uop_ready) state_n = STREAM;
      STREAM:  if (both_done) state_n = last ? DRAIN : ISSUE;
      DRAIN:   if (done) state_n = IDLE;
      default: ;
    endcase
    if (accept) state_n = zero_cmd ? DRAIN : ISSUE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter        <= '0;
      target      <= '0;
      out_idx     <= '0;
      res_cnt     <= '0;
      nram_cnt    <= '0;
      wram_cnt    <= '0;
      nram_base   <= '0;
      wram_ptr    <= '0;
      out_base    <= '0;
      out_wr_en   <= 1'b0;
      out_wr_addr <= '0;
      out_wr_data <= '0;
    end else begin
      if (uop_valid && uop_ready) begin
        nram_cnt <= '0;
        wram_cnt <= '0;
      end
      if (nram_fire) nram_cnt <= nram_cnt + CW'(1);
      if (wram_fire) begin
        wram_cnt <= wram_cnt + CW'(1);
        wram_ptr <= wram_ptr + AW'(1);
      end
      if (state == STREAM && both_done && !last) out_idx <= out_idx + CW'(1);
      out_wr_en <= capture;
      if (capture) begin
        out_wr_addr <= out_base + AW'(res_cnt);
        out_wr_data <= wr_data;
        res_cnt     <= res_cnt + CW'(1);
      end
      if (accept) begin
        iter      <= cmd_iter;
        target    <= zero_cmd ? '0 : cmd_nout;
        nram_base <= cmd_nram_addr;
        wram_ptr  <= cmd_wram_addr;
        out_base  <= cmd_out_addr;
        out_idx   <= '0;
        res_cnt   <= '0;
      end
    end
  end
endmodule

// File: tb/tb_mpe_scheduler.sv
// tb_mpe_scheduler: directed commands checked against a queue-based model of uops, read addresses, writes and done timing.
module tb_mpe_scheduler;
  localparam int AW = 16;
  localparam int CW = 8;
`ifdef MPE_SCHED_RELU_EN
  localparam logic [31:0] EXP_NEG3 = 32'h0;
  localparam logic [31:0] EXP_F0 = 32'h0;
`else
  localparam logic [31:0] EXP_NEG3 = 32'hFFFFFFFD;
  localparam logic [31:0] EXP_F0 = 32'hFFFFFFF0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [CW-1:0] cmd_iter = '0, cmd_nout = '0;
  logic [AW-1:0] cmd_nram_addr = '0, cmd_wram_addr = '0, cmd_out_addr = '0;
  logic [CW-1:0] uop;
  logic uop_valid, uop_ready = 1'b1;
  logic [AW-1:0] nram_rd_addr, wram_rd_addr, out_wr_addr;
  logic nram_rd_valid, nram_rd_ready = 1'b1, wram_rd_valid, wram_rd_ready = 1'b1;
  logic [31:0] pe_result = '0, out_wr_data;
  logic pe_vld = 1'b0, out_wr_en, busy, done;

  mpe_scheduler #(.AW(AW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_iter(cmd_iter), .cmd_nout(cmd_nout),
    .cmd_nram_addr(cmd_nram_addr), .cmd_wram_addr(cmd_wram_addr), .cmd_out_addr(cmd_out_addr),
    .uop(uop), .uop_valid(uop_valid), .uop_ready(uop_ready),
    .nram_rd_addr(nram_rd_addr), .nram_rd_valid(nram_rd_valid), .nram_rd_ready(nram_rd_ready),
    .wram_rd_addr(wram_rd_addr), .wram_rd_valid(wram_rd_valid), .wram_rd_ready(wram_rd_ready),
    .pe_result(pe_result), .pe_vld(pe_vld),
    .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [CW-1:0] q_uop[$];
  logic [AW-1:0] q_nram[$], q_wram[$], q_waddr[$], log_wram[$];
  logic [31:0] q_wdata[$], res[$], log_wdata[$];
  int pend = 0, beats = 0, cur_iter = 0, cyc = 0, ustall = 0, n_done = 0;
  int since_wr = -1, since_rd = -1;
  bit bp = 0, stray = 0, zero_flag = 0, arm = 0;
  bit prev_uf = 0, prev_acc_nz = 0, hu = 0, hn = 0, hw = 0;
  logic [CW-1:0] pu;
  logic [AW-1:0] pn, pw;

  function automatic logic [31:0] relu(input logic [31:0] x);
`ifdef MPE_SCHED_RELU_EN
    return x[31] ? 32'd0 : x;
`else
    return x;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    total++;
    bad++;
    $display("FAIL %s: got an unexpected transfer, expected none", name);
  endtask

  // ready patterns and a PE that answers once per completed output
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    ustall = uop_valid ? ustall + 1 : 0;
    uop_ready = !bp || ustall > 3;
    wram_rd_ready = !bp || (cyc % 4 == 0) || (cyc % 4 == 3);
    if (stray) begin
      pe_vld = 1'b1;
      pe_result = 32'h1234;
    end else if (pend > 0 && res.size() > 0) begin
      pe_vld = 1'b1;
      pe_result = res.pop_front();
      pend--;
    end else pe_vld = 1'b0;
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      {prev_uf, prev_acc_nz, hu, hn, hw, arm} = '0;
      since_wr = -1;
      since_rd = -1;
      continue;
    end
    if (since_wr >= 0) since_wr++;
    if (since_rd >= 0) since_rd++;
    chk("done", done, arm && since_wr >= 1 && since_rd >= 2);
    if (done) begin
      n_done++;
      arm = 0;
      chk("done_ready", cmd_ready, 1);
    end
    if (prev_acc_nz) chk("uop_rise", uop_valid, 1);
    if (prev_uf) chk("rd_rise", {nram_rd_valid, wram_rd_valid}, 2'b11);
    if (hu) chk("uop_hold", {uop_valid, uop}, {1'b1, pu});
    if (hn) chk("nram_hold", {nram_rd_valid, nram_rd_addr}, {1'b1, pn});
    if (hw) chk("wram_hold", {wram_rd_valid, wram_rd_addr}, {1'b1, pw});
    hu = uop_valid && !uop_ready;
    hn = nram_rd_valid && !nram_rd_ready;
    hw = wram_rd_valid && !wram_rd_ready;
    pu = uop;
    pn = nram_rd_addr;
    pw = wram_rd_addr;
    prev_uf = uop_valid && uop_ready;
    if (uop_valid && uop_ready) begin
      if (q_uop.size() == 0) miss("uop");
      else chk("uop", uop, q_uop.pop_front());
    end
    if (nram_rd_valid && nram_rd_ready) begin
      if (q_nram.size() == 0) miss("nram_addr");
      else begin
        chk("nram_addr", nram_rd_addr, q_nram.pop_front());
        beats++;
        if (beats == cur_iter) begin
          beats = 0;
          pend++;
        end
        if (q_nram.size() == 0 && q_wram.size() == 0) since_rd = 0;
      end
    end
    if (wram_rd_valid && wram_rd_ready) begin
      if (q_wram.size() == 0) miss("wram_addr");
      else begin
        chk("wram_addr", wram_rd_addr, q_wram.pop_front());
        log_wram.push_back(wram_rd_addr);
        if (q_nram.size() == 0 && q_wram.size() == 0) since_rd = 0;
      end
    end
    if (out_wr_en) begin
      if (q_waddr.size() == 0) miss("wr");
      else begin
        chk("wr_addr", out_wr_addr, q_waddr.pop_front());
        chk("wr_data", out_wr_data, q_wdata.pop_front());
        log_wdata.push_back(out_wr_data);
        if (q_waddr.size() == 0) since_wr = 0;
      end
    end
    prev_acc_nz = 0;
    if (cmd_valid && cmd_ready) begin
      arm = 1;
      if (zero_flag) begin
        since_wr = 0;
        since_rd = 1;
      end else begin
        since_wr = -1;
        since_rd = -1;
        prev_acc_nz = 1;
      end
    end
  end

  task automatic start_cmd(input int it, input int nout, input logic [AW-1:0] nb, input logic [AW-1:0] wb,
                           input logic [AW-1:0] ob, input logic [31:0] r0);
    zero_flag = (it == 0 || nout == 0);
    cur_iter = it;
    beats = 0;
    if (!zero_flag)
      for (int k = 0; k < nout; k++) begin
        q_uop.push_back(CW'(it));
        for (int b = 0; b < it; b++) begin
          q_nram.push_back(nb + AW'(b));
          q_wram.push_back(wb + AW'(k * it + b));
        end
        q_waddr.push_back(ob + AW'(k));
        q_wdata.push_back(relu(r0 - 32'(8 * k)));
        res.push_back(r0 - 32'(8 * k));
      end
    @(posedge clk);
    #2;
    cmd_valid = 1'b1;
    cmd_iter = CW'(it);
    cmd_nout = CW'(nout);
    cmd_nram_addr = nb;
    cmd_wram_addr = wb;
    cmd_out_addr = ob;
    @(posedge clk);
    #2;
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input int it, input int nout, input logic [AW-1:0] nb, input logic [AW-1:0] wb,
                         input logic [AW-1:0] ob, input logic [31:0] r0);
    int n0;
    bit ok;
    n0 = n_done;
    ok = 0;
    start_cmd(it, nout, nb, wb, ob, r0);
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (n_done != n0) ok = 1;
    end
    chk("done_timeout", ok, 1);
    repeat (3) @(posedge clk);
    chk("one_done", n_done - n0, 1);
    chk("model_drained", q_uop.size() + q_nram.size() + q_wram.size() + q_waddr.size() + res.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready_busy_done", {cmd_ready, busy, done}, 3'b100);
    chk("rst_valids", {uop_valid, nram_rd_valid, wram_rd_valid, out_wr_en}, 4'b0);
    chk("rst_uop", uop, 0);
    chk("rst_addrs", {nram_rd_addr, wram_rd_addr}, 0);
    chk("rst_wr", {out_wr_addr, out_wr_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    log_wram.delete(); log_wdata.delete();
    run_cmd(4, 2, 16'h0100, 16'h0200, 16'h0040, 32'd5);
    chk("basic_wram_n", log_wram.size(), 8);
    if (log_wram.size() == 8) chk("basic_wram_last", log_wram[7], 16'h0207);
    chk("basic_wr_n", log_wdata.size(), 2);
    if (log_wdata.size() == 2) begin
      chk("basic_wr0", log_wdata[0], 32'd5);
      chk("basic_wr1", log_wdata[1], EXP_NEG3);
    end

    bp = 1;
    log_wram.delete();
    run_cmd(3, 2, 16'h0010, 16'h0020, 16'h0080, 32'd100);
    bp = 0;
    chk("bp_wram_n", log_wram.size(), 6);
    if (log_wram.size() == 6) chk("bp_wram_last", log_wram[5], 16'h0025);

    log_wram.delete();
    run_cmd(0, 3, 16'h0001, 16'h0002, 16'h0003, 32'd1);
    run_cmd(2, 0, 16'h0001, 16'h0002, 16'h0003, 32'd1);
    chk("zero_no_reads", log_wram.size(), 0);

    log_wram.delete();
    run_cmd(3, 1, 16'h0000, 16'hFFFE, 16'h0000, 32'd7);
    chk("wrap_n", log_wram.size(), 3);
    if (log_wram.size() == 3) chk("wrap_addrs", {log_wram[0], log_wram[1], log_wram[2]}, {16'hFFFE, 16'hFFFF, 16'h0000});

    stray = 1;
    repeat (2) @(posedge clk);
    #2;
    stray = 0;
    @(negedge clk);
    chk("idle_pe_ignored", out_wr_en, 0);

    start_cmd(8, 2, 16'h0400, 16'h0500, 16'h0600, 32'd3);
    for (int i = 0; i < 50 && !nram_rd_valid; i++) @(negedge clk);
    chk("abort_in_stream", nram_rd_valid, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_valids", {uop_valid, nram_rd_valid, wram_rd_valid, out_wr_en, done, busy}, 6'b0);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_addrs", {uop, nram_rd_addr, wram_rd_addr}, 0);
    q_uop.delete(); q_nram.delete(); q_wram.delete(); q_waddr.delete(); q_wdata.delete(); res.delete();
    pend = 0;
    beats = 0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    run_cmd(2, 1, 16'h0700, 16'h0800, 16'h0900, 32'd9);

    log_wdata.delete();
    run_cmd(1, 1, 16'h0000, 16'h0000, 16'h0300, 32'hFFFFFFF0);
    chk("relu_n", log_wdata.size(), 1);
    if (log_wdata.size() == 1) chk("relu_data", log_wdata[0], EXP_F0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mpe_scheduler.md
# mpe_scheduler

Command-level sequencer for the matrix PE. It takes one matrix-vector command (beats per output, number of outputs, base addresses) and issues one uop per output to the PE instruction port. It streams the matching NRAM/WRAM read addresses and collects the 32-bit results into a result-buffer write port. It sits between the top-level instruction decoder and the PE/SRAM read path, and replaces direct decoder-to-PE uop driving.

## Interface
Parameters:
- AW, 16, SRAM/result-buffer address width
- CW, 8, width of iter and nout fields; uop width equals CW

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid / cmd_ready  in/out  1  command handshake
- cmd_iter  in  CW  512-bit beats per output (PE uop value)
- cmd_nout  in  CW  number of outputs
- cmd_nram_addr, cmd_wram_addr, cmd_out_addr  in  AW  base addresses
- uop  out  CW  uop to PE instruction port
- uop_valid / uop_ready  out/in  1  PE uop handshake
- nram_rd_addr  out  AW  neuron read address
- nram_rd_valid / nram_rd_ready  out/in  1  NRAM read-request handshake
- wram_rd_addr  out  AW  weight read address
- wram_rd_valid / wram_rd_ready  out/in  1  WRAM read-request handshake
- pe_result  in  32  PE result
- pe_vld  in  1  PE result valid
- out_wr_en  out  1  result write strobe
- out_wr_addr  out  AW  result write address
- out_wr_data  out  32  result write data
- busy  out  1  command in flight
- done  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, ISSUE, STREAM, DRAIN. Reset to IDLE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch all fields and clear out_idx, res_cnt and wram_ptr (wram_ptr loads cmd_wram_addr).
  - If cmd_iter==0 or cmd_nout==0, go to DRAIN with the target forced to 0. This means no uops and no reads are issued.
  - Otherwise go to ISSUE.
- ISSUE:
  - uop_valid=1, uop=iter.
  - On uop_valid&uop_ready, clear nram_cnt and wram_cnt, then go to STREAM.
- STREAM (both ports are independent):
  - nram_rd_valid = nram_cnt<iter; nram_rd_addr = nram_base+nram_cnt.
  - wram_rd_valid = wram_cnt<iter; wram_rd_addr = wram_ptr.
  - Each accepted beat increments its own counter. A WRAM beat also increments wram_ptr.
  - When both counters equal iter:
    - If out_idx==nout-1, go to DRAIN.
    - Otherwise increment out_idx and go to ISSUE.
- DRAIN: when res_cnt==target (nout) and no write is pending, pulse done and go to IDLE.
- Result capture:
  - pe_vld in any non-IDLE state registers out_wr_data=pe_result and out_wr_addr=out_base+res_cnt, and increments res_cnt.
  - pe_vld in IDLE is ignored.
  - pe_vld after res_cnt==nout is ignored.
- Address arithmetic is AW-bit modulo (wraps silently). Counters are CW bits. Comparisons use CW-bit values.
- busy = state!=IDLE.

## Timing
- Reset values:
  - cmd_ready=1.
  - uop_valid=0, nram_rd_valid=0, wram_rd_valid=0, out_wr_en=0, busy=0, done=0.
  - uop=0 and all addresses/data=0.
- All outputs are registered or decoded from state/counters only. There are no combinational paths from uop_ready, nram_rd_ready or wram_rd_ready to any output.
- Command accepted at cycle t: uop_valid=1 at t+1.
- Read valids rise the cycle after the uop handshake.
- Once a read valid is asserted, its address holds until accepted.
- pe_vld at cycle t gives out_wr_en=1 at t+1 for exactly one cycle.
- The final write at t+1 gives done=1 at t+2, with cmd_ready=1 at t+2.
- Zero-length command: accepted at t, done at t+1.
- A result arriving in the same cycle as the STREAM->ISSUE transition is captured normally.
- Reset mid-command aborts immediately: all valids drop asynchronously and no done pulse is produced.

## Configuration
- MPE_SCHED_RELU_EN defined: out_wr_data = pe_result[31] ? 0 : pe_result (ReLU on signed result).
- Undefined: out_wr_data = pe_result unmodified.

## Test plan
- Basic command:
  - Stimulus: iter=4, nout=2, nram=0x100, wram=0x200, out=0x40, all readies held high.
  - Required: uops 4,4; NRAM addrs 0x100-0x103 twice; WRAM addrs 0x200-0x207.
  - Required: PE results 5 and -3 written to 0x40 and 0x41; one done pulse.
- Backpressure:
  - Stimulus: wram_rd_ready toggling 1,0,0,1 and uop_ready low for 3 cycles.
  - Required: addresses held stable while stalled; no beat lost or duplicated; counts exact.
- Zero length:
  - Stimulus: iter=0 (and separately nout=0).
  - Required: no uop_valid, no read valids; done one cycle after accept.
- Address wrap:
  - Stimulus: wram=0xFFFE, iter=3, nout=1.
  - Required: WRAM addrs 0xFFFE, 0xFFFF, 0x0000.
- Reset abort:
  - Stimulus: rst_n low mid-STREAM, then a new command with iter=2, nout=1.
  - Required: all outputs at reset values; second command completes normally with a single done.
- ReLU macro:
  - Stimulus: pe_result=0xFFFFFFF0, with and without MPE_SCHED_RELU_EN.
  - Required: out_wr_data is 0 with the macro and 0xFFFFFFF0 without it.
